// File: rtl/bayes_score_argmax_if.sv
// Index stream, pixel/likelihood memory ports and result signals
// of the naive-Bayes scoring block.
interface bayes_score_argmax_if #(
  parameter int LW = 16,
  parameter int AW = 24
);
  logic [3:0]        in_c_idx;
  logic [9:0]        in_attri_idx;
  logic [9:0]        pix_addr;
  logic              pix_rdata;
  logic [13:0]       lik_addr;
  logic [2*LW-1:0]   lik_rdata;
  logic              busy;
  logic              result_valid;
  logic [3:0]        result_digit;
  logic [AW-1:0]     result_score;

  modport master (
    output in_c_idx,
    output in_attri_idx,
    output pix_rdata,
    output lik_rdata,
    input  pix_addr,
    input  lik_addr,
    input  busy,
    input  result_valid,
    input  result_digit,
    input  result_score
  );

  modport slave (
    input  in_c_idx,
    input  in_attri_idx,
    input  pix_rdata,
    input  lik_rdata,
    output pix_addr,
    output lik_addr,
    output busy,
    output result_valid,
    output result_digit,
    output result_score
  );
endinterface

// File: rtl/bayes_score_argmax.sv
// Naive-Bayes log-probability scoring per class with a running
// argmax; one classification result per image.
module bayes_score_argmax #(
  parameter int LW     = 16,
  parameter int AW     = 24,
  parameter int NCLASS = 10,
  parameter int NATTR  = 784
) (
  input  logic clk,
  input  logic rstn,
  bayes_score_argmax_if.slave io
);

  localparam logic [3:0] CLAST = 4'(NCLASS - 1);
  localparam logic [9:0] ALAST = 10'(NATTR);
  localparam logic signed [AW-1:0] SMAX =
    {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic in_ok;
  logic is_first;
  logic is_last;
  logic take;
  logic start;
  logic fire;

  logic       s1_v;
  logic [3:0] s1_c;
  logic [9:0] s1_a;

  logic       tag_v;
  logic [3:0] tag_c;

  logic signed [LW-1:0] lik_hi;
  logic signed [LW-1:0] lik_lo;
  logic signed [LW-1:0] term;
  logic signed [AW-1:0] term_ext;
  logic signed [AW:0]   acc_sum;
  logic signed [AW-1:0] acc_sat;
  logic signed [AW-1:0] acc;

  logic signed [AW-1:0] best_score;
  logic [3:0]           best_digit;
  logic                 win;
  logic signed [AW-1:0] new_score;
  logic [3:0]           new_digit;

  logic              busy_q;
  logic              rv_q;
  logic [3:0]        digit_q;
  logic [AW-1:0]     score_q;

  assign io.pix_addr = io.in_attri_idx;
  assign io.lik_addr = {io.in_c_idx, io.in_attri_idx};

  assign in_ok = (io.in_c_idx <= CLAST) &&
                 (io.in_attri_idx <= ALAST);
  assign is_first = in_ok &&
                    (io.in_c_idx == 4'd0) &&
                    (io.in_attri_idx == 10'd0);
  assign is_last = in_ok &&
                   (io.in_c_idx == CLAST) &&
                   (io.in_attri_idx == ALAST);

  assign fire = (state == FINISH) && tag_v &&
                (tag_c == CLAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_first) begin
          start    = 1'b1;
          take     = 1'b1;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        take = in_ok;
        if (is_last) begin
          state_nx = FINISH;
        end
      end
      FINISH: begin
        if (fire) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // The prior sits in the lo field of the class-end word.
  assign lik_hi = io.lik_rdata[2*LW-1:LW];
  assign lik_lo = io.lik_rdata[LW-1:0];
  assign term = ((s1_a != ALAST) && io.pix_rdata) ?
                lik_hi : lik_lo;
  assign term_ext = AW'(term);
  assign acc_sum = (AW+1)'(acc) + (AW+1)'(term_ext);

  always_comb begin
    acc_sat = acc_sum[AW-1:0];
    if (acc_sum[AW] != acc_sum[AW-1]) begin
      acc_sat = acc_sum[AW] ? SMIN : SMAX;
    end
  end

  // Strict compare so a tie keeps the lower class.
  assign win = (tag_c == 4'd0) || (acc > best_score);
  assign new_score = win ? acc : best_score;
  assign new_digit = win ? tag_c : best_digit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v       <= 1'b0;
      s1_c       <= '0;
      s1_a       <= '0;
      tag_v      <= 1'b0;
      tag_c      <= '0;
      acc        <= '0;
      best_score <= '0;
      best_digit <= '0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      digit_q    <= '0;
      score_q    <= '0;
    end else begin
      s1_v <= take;
      if (take) begin
        s1_c <= io.in_c_idx;
        s1_a <= io.in_attri_idx;
      end
      tag_v <= s1_v && (s1_a == ALAST);
      tag_c <= s1_c;
      if (s1_v) begin
        acc <= (s1_a == 10'd0) ? term_ext : acc_sat;
      end
      if (tag_v) begin
        best_score <= new_score;
        best_digit <= new_digit;
      end
      rv_q <= fire;
      if (fire) begin
        digit_q <= new_digit;
        score_q <= new_score;
      end
      if (start) begin
        busy_q <= 1'b1;
      end else if (fire) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign io.busy         = busy_q;
  assign io.result_valid = rv_q;
  assign io.result_digit = digit_q;
  assign io.result_score = score_q;

endmodule

// File: tb/tb_bayes_score_argmax.sv
// Directed image runs against a per-class ROM model; expected
// results are queued at stimulus time and checked on result_valid.
module tb_bayes_score_argmax;

  localparam int LW = 16;
  localparam int AW = 16;
  localparam int NC = 10;
  localparam int NA = 784;

  typedef struct {
    int digit;
    int score;
    int due;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit   prev_rv;
  exp_t q[$];

  logic                 img [0:NA-1];
  logic signed [15:0]   hi [0:NC-1];
  logic signed [15:0]   lo [0:NC-1];
  logic signed [15:0]   pr [0:NC-1];
  logic                 pix_q;
  logic [2*LW-1:0]      lik_q;

  bayes_score_argmax_if #(.LW(LW), .AW(AW)) bus ();

  bayes_score_argmax #(
    .LW(LW), .AW(AW), .NCLASS(NC), .NATTR(NA)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    int c;
    int a;
    c = int'(bus.lik_addr[13:10]);
    a = int'(bus.lik_addr[9:0]);
    pix_q <= (int'(bus.pix_addr) < NA) ?
             img[bus.pix_addr] : 1'b0;
    if (c >= NC) lik_q <= '0;
    else if (a < NA) lik_q <= {hi[c], lo[c]};
    else lik_q <= {16'sh1234, pr[c]};
  end

  assign bus.pix_rdata = pix_q;
  assign bus.lik_rdata = lik_q;

  task automatic check(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.result_valid) begin
      check("pulse_expected", int'(q.size() > 0), 1);
      check("pulse_width", int'(prev_rv), 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("digit", int'(bus.result_digit), e.digit);
        check("score", $signed(bus.result_score), e.score);
        check("latency", cyc, e.due);
        check("busy_drop", int'(bus.busy), 0);
      end
    end
    prev_rv = bus.result_valid;
  end

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int model(input int c);
    int acc;
    int t;
    acc = 0;
    for (int a = 0; a <= NA; a++) begin
      if (a < NA) t = img[a] ? int'(hi[c]) : int'(lo[c]);
      else t = int'(pr[c]);
      acc = (a == 0) ? t : sat16(acc + t);
    end
    return acc;
  endfunction

  task automatic step(input int c, input int a);
    @(posedge clk);
    #1;
    bus.in_c_idx     = 4'(c);
    bus.in_attri_idx = 10'(a);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(10, 800);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    hold(2);
    rstn = 1'b1;
  endtask

  task automatic rand_rom();
    for (int c = 0; c < NC; c++) begin
      hi[c] = 16'($signed($urandom_range(0, 100)) - 50);
      lo[c] = 16'($signed($urandom_range(0, 100)) - 50);
      pr[c] = 16'($signed($urandom_range(0, 400)) - 200);
    end
  endtask

  task automatic rand_img();
    for (int a = 0; a < NA; a++) img[a] = 1'($urandom);
  endtask

  task automatic run_image(input string tag,
                           input bit gaps,
                           input bit reclear,
                           output exp_t e);
    int best;
    int s;
    e.digit = 0;
    best = model(0);
    for (int c = 1; c < NC; c++) begin
      s = model(c);
      if (s > best) begin
        best = s;
        e.digit = c;
      end
    end
    e.score = best;
    for (int c = 0; c < NC; c++) begin
      if (reclear && c == 2) begin
        for (int a = 0; a < 30; a++) step(c, a);
      end
      for (int a = 0; a <= NA; a++) begin
        step(c, a);
        if (c == 0 && a == 5) check({tag, "_busy"}, int'(bus.busy), 1);
      end
      if (gaps && c < NC - 1) begin
        hold(3);
        step(12, 5);
        step(3, 900);
      end
    end
    e.due = cyc + 3;
    q.push_back(e);
    hold(6);
    check({tag, "_drained"}, q.size(), 0);
    if (q.size() > 0) q.delete();
  endtask

  initial begin
    exp_t e;
    cyc = 0;
    n_cmp = 0;
    n_bad = 0;
    prev_rv = 1'b0;
    rstn = 1'b0;
    bus.in_c_idx = 4'd10;
    bus.in_attri_idx = 10'd800;
    for (int a = 0; a < NA; a++) img[a] = 1'b0;
    for (int c = 0; c < NC; c++) begin
      hi[c] = '0;
      lo[c] = '0;
      pr[c] = '0;
    end
    hold(3);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.result_valid), 0);
    check("rst_digit", int'(bus.result_digit), 0);
    check("rst_score", $signed(bus.result_score), 0);
    rstn = 1'b1;
    hold(2);

    // prior only
    rand_img();
    for (int c = 0; c < NC; c++) pr[c] = 16'(c * 10);
    run_image("prior", 1'b0, 1'b0, e);
    check("prior_model_digit", e.digit, 9);
    check("prior_model_score", e.score, 90);

    // pixel select
    do_reset();
    for (int a = 0; a < NA; a++) img[a] = 1'b1;
    for (int c = 0; c < NC; c++) begin
      hi[c] = (c == 3) ? -16'sd1 : -16'sd2;
      lo[c] = -16'sd100;
      pr[c] = '0;
    end
    run_image("pixsel", 1'b0, 1'b0, e);
    check("pixsel_model_score", e.score, -784);

    // tie keeps class 0
    do_reset();
    rand_img();
    for (int c = 0; c < NC; c++) begin
      hi[c] = -16'sd5;
      lo[c] = -16'sd5;
      pr[c] = '0;
    end
    run_image("tie", 1'b0, 1'b0, e);
    check("tie_model_score", e.score, -3920);

    // saturation
    do_reset();
    for (int a = 0; a < NA; a++) img[a] = 1'b1;
    for (int c = 0; c < NC; c++) begin
      hi[c] = (c == 5) ? 16'sd32767 : 16'sd0;
      lo[c] = -16'sd3;
      pr[c] = '0;
    end
    run_image("sat", 1'b0, 1'b0, e);
    check("sat_model_score", e.score, 32767);

    // reset mid-stream during class 4
    do_reset();
    rand_img();
    rand_rom();
    for (int c = 0; c <= 4; c++) begin
      for (int a = 0; a <= ((c == 4) ? 100 : NA); a++) step(c, a);
    end
    rstn = 1'b0;
    hold(2);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_digit", int'(bus.result_digit), 0);
    check("midrst_score", $signed(bus.result_score), 0);
    rstn = 1'b1;
    hold(8);
    check("midrst_valid", int'(bus.result_valid), 0);

    // full rerun with gaps and a re-cleared class
    rand_rom();
    run_image("rerun", 1'b1, 1'b1, e);

    // ignored indices after the result
    hold(100);
    step(2, 0);
    hold(10);
    check("ign_busy", int'(bus.busy), 0);
    check("ign_valid", int'(bus.result_valid), 0);
    check("ign_digit", int'(bus.result_digit), e.digit);
    check("ign_score", $signed(bus.result_score), e.score);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
